// File: rtl/voice_mixer_pkg.sv
// Shared helpers for the voice mixer: gain/pan constants, config clamping and output saturation.
// Pure functions only; no state.
package voice_mixer_pkg;

   function automatic int unity_gain(input int gain_w);
      return 1 << gain_w;
   endfunction

   function automatic int reset_pan(input int gain_w);
      return 1 << (gain_w - 1);
   endfunction

   function automatic int clamp_cfg(input int v, input int gain_w);
      return (v > unity_gain(gain_w)) ? unity_gain(gain_w) : v;
   endfunction

   function automatic longint sat_hi(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   function automatic longint sat_lo(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

   function automatic longint sat_val(input longint v, input int w);
      if (v > sat_hi(w)) return sat_hi(w);
      if (v < sat_lo(w)) return sat_lo(w);
      return v;
   endfunction

   function automatic logic sat_clips(input longint v, input int w);
      return (v > sat_hi(w)) || (v < sat_lo(w));
   endfunction

endpackage

// File: rtl/voice_gain_pan.sv
// Gain/pan stage: registers sample, tag, gain and pan on the S1 edge; left/right products are combinational from those registers.
// One register of latency, no backpressure.
module voice_gain_pan
   import voice_mixer_pkg::*;
#(
   parameter int VOICE_W  = 8,
   parameter int SAMPLE_W = 16,
   parameter int GAIN_W   = 8
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_valid,
   input  logic [VOICE_W-1:0]         i_tag,
   input  logic signed [SAMPLE_W-1:0] i_sample,
   input  logic [GAIN_W:0]            i_gain,
   input  logic [GAIN_W:0]            i_pan,
   output logic                       o_valid,
   output logic [VOICE_W-1:0]         o_tag,
   output logic signed [SAMPLE_W:0]   o_left,
   output logic signed [SAMPLE_W:0]   o_right
);
   localparam int PW = SAMPLE_W + GAIN_W + 2;
   localparam int LW = SAMPLE_W + GAIN_W + 3;

   logic signed [SAMPLE_W-1:0] sample_q;
   logic [GAIN_W:0]            gain_q;
   logic [GAIN_W:0]            pan_q;
   logic [GAIN_W:0]            pan_l;
   logic signed [PW-1:0]       prod_p;
   logic signed [SAMPLE_W:0]   p;
   logic signed [LW-1:0]       prod_l;
   logic signed [LW-1:0]       prod_r;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_valid  <= 1'b0;
         o_tag    <= '0;
         sample_q <= '0;
         gain_q   <= '0;
         pan_q    <= '0;
      end else begin
         o_valid  <= i_valid;
         o_tag    <= i_tag;
         sample_q <= i_sample;
         gain_q   <= i_gain;
         pan_q    <= i_pan;
      end
   end

   // Gain and pan are unsigned; a zero MSB keeps them positive in signed products.
   assign prod_p = PW'(sample_q) * PW'($signed({1'b0, gain_q}));
   assign p      = (SAMPLE_W + 1)'(prod_p >>> GAIN_W);
   assign pan_l  = (GAIN_W + 1)'(unity_gain(GAIN_W)) - pan_q;
   assign prod_l = LW'(p) * LW'($signed({1'b0, pan_l}));
   assign prod_r = LW'(p) * LW'($signed({1'b0, pan_q}));
   assign o_left  = (SAMPLE_W + 1)'(prod_l >>> GAIN_W);
   assign o_right = (SAMPLE_W + 1)'(prod_r >>> GAIN_W);

endmodule

// File: rtl/voice_mixer_scheduler.sv
// Voice slot scheduler plus stereo mixer: frame emitted two edges after the last voice's sample is accepted.
// No backpressure: samples are accepted every cycle, out-of-range tags are dropped.
module voice_mixer_scheduler
   import voice_mixer_pkg::*;
#(
   parameter int NUM_VOICES = 256,
   parameter int VOICE_W    = 8,
   parameter int STAGES     = 3,
   parameter int SAMPLE_W   = 16,
   parameter int GAIN_W     = 8,
   parameter int OUT_W      = 24,
   localparam int SLOT_W    = (STAGES > 1) ? $clog2(STAGES) : 1
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_enable,
   output logic [VOICE_W-1:0]         o_voice_index,
   output logic [SLOT_W-1:0]          o_slot,
   output logic                       o_frame_start,
   input  logic                       i_sample_valid,
   input  logic [VOICE_W-1:0]         i_sample_voice,
   input  logic signed [SAMPLE_W-1:0] i_sample,
   input  logic                       i_cfg_we,
   input  logic [VOICE_W-1:0]         i_cfg_voice,
   input  logic [GAIN_W:0]            i_cfg_gain,
   input  logic [GAIN_W:0]            i_cfg_pan,
   input  logic                       i_clip_clear,
   output logic signed [OUT_W-1:0]    o_left,
   output logic signed [OUT_W-1:0]    o_right,
   output logic                       o_valid,
   output logic                       o_clip_left,
   output logic                       o_clip_right
);
   localparam int VIDX_W = $clog2(NUM_VOICES);
   localparam int CFG_W  = GAIN_W + 1;
   localparam int ACC_W  = OUT_W + VOICE_W + 1;

   logic [CFG_W-1:0]         gain_mem [NUM_VOICES];
   logic [CFG_W-1:0]         pan_mem  [NUM_VOICES];
   logic                     rd_ok, wr_ok, last;
   logic [VIDX_W-1:0]        rd_idx, wr_idx;
   logic [CFG_W-1:0]         rd_gain, rd_pan;
   logic                     gp_vld;
   logic [VOICE_W-1:0]       gp_tag;
   logic signed [SAMPLE_W:0] gp_left, gp_right;
   logic signed [ACC_W-1:0]  acc_l, acc_r, sum_l, sum_r;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_slot        <= '0;
         o_voice_index <= '0;
      end else if (i_enable) begin
         if (o_slot == SLOT_W'(STAGES - 1)) begin
            o_slot        <= '0;
            o_voice_index <= (o_voice_index == VOICE_W'(NUM_VOICES - 1)) ? '0
                             : o_voice_index + VOICE_W'(1);
         end else begin
            o_slot <= o_slot + SLOT_W'(1);
         end
      end
   end

   assign o_frame_start = (o_voice_index == '0) && (o_slot == '0);

   assign rd_ok   = i_sample_valid && ({1'b0, i_sample_voice} < (VOICE_W + 1)'(NUM_VOICES));
   assign rd_idx  = i_sample_voice[VIDX_W-1:0];
   assign rd_gain = gain_mem[rd_idx];
   assign rd_pan  = pan_mem[rd_idx];
   assign wr_ok   = i_cfg_we && ({1'b0, i_cfg_voice} < (VOICE_W + 1)'(NUM_VOICES));
   assign wr_idx  = i_cfg_voice[VIDX_W-1:0];

   // Reads see the pre-edge array contents, so a same-edge write is not visible yet.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            gain_mem[i] <= CFG_W'(unity_gain(GAIN_W));
            pan_mem[i]  <= CFG_W'(reset_pan(GAIN_W));
         end
      end else if (wr_ok) begin
         gain_mem[wr_idx] <= CFG_W'(clamp_cfg(int'(i_cfg_gain), GAIN_W));
         pan_mem[wr_idx]  <= CFG_W'(clamp_cfg(int'(i_cfg_pan), GAIN_W));
      end
   end

   voice_gain_pan #(
      .VOICE_W  (VOICE_W),
      .SAMPLE_W (SAMPLE_W),
      .GAIN_W   (GAIN_W)
   ) u_gain_pan (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_valid  (rd_ok),
      .i_tag    (i_sample_voice),
      .i_sample (i_sample),
      .i_gain   (rd_gain),
      .i_pan    (rd_pan),
      .o_valid  (gp_vld),
      .o_tag    (gp_tag),
      .o_left   (gp_left),
      .o_right  (gp_right)
   );

   assign sum_l = acc_l + ACC_W'(gp_left);
   assign sum_r = acc_r + ACC_W'(gp_right);
   assign last  = gp_vld && (gp_tag == VOICE_W'(NUM_VOICES - 1));

   // Clip set is ordered after clear so a coincident saturation keeps the flag.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         acc_l        <= '0;
         acc_r        <= '0;
         o_left       <= '0;
         o_right      <= '0;
         o_valid      <= 1'b0;
         o_clip_left  <= 1'b0;
         o_clip_right <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (i_clip_clear) begin
            o_clip_left  <= 1'b0;
            o_clip_right <= 1'b0;
         end
         if (last) begin
            acc_l   <= '0;
            acc_r   <= '0;
            o_valid <= 1'b1;
            o_left  <= OUT_W'(sat_val(longint'(sum_l), OUT_W));
            o_right <= OUT_W'(sat_val(longint'(sum_r), OUT_W));
            if (sat_clips(longint'(sum_l), OUT_W)) o_clip_left  <= 1'b1;
            if (sat_clips(longint'(sum_r), OUT_W)) o_clip_right <= 1'b1;
         end else if (gp_vld) begin
            acc_l <= sum_l;
            acc_r <= sum_r;
         end
      end
   end

endmodule

// File: tb/tb_voice_mixer_scheduler.sv
// Bench for voice_mixer_scheduler: frame table, hand-written corner sequences and a random run against a behavioural model.
module tb_voice_mixer_scheduler;
   localparam int NV = 4;
   localparam int OW = 16;

   logic               i_clk = 1'b0;
   logic               i_reset = 1'b1;
   logic               i_enable = 1'b0;
   logic [7:0]         o_voice_index;
   logic [1:0]         o_slot;
   logic               o_frame_start;
   logic               i_sample_valid = 1'b0;
   logic [7:0]         i_sample_voice = '0;
   logic signed [15:0] i_sample = '0;
   logic               i_cfg_we = 1'b0;
   logic [7:0]         i_cfg_voice = '0;
   logic [8:0]         i_cfg_gain = '0;
   logic [8:0]         i_cfg_pan = '0;
   logic               i_clip_clear = 1'b0;
   logic signed [OW-1:0] o_left, o_right;
   logic               o_valid, o_clip_left, o_clip_right;

   int checks = 0;
   int errors = 0;

   voice_mixer_scheduler #(
      .NUM_VOICES(NV), .VOICE_W(8), .STAGES(3), .SAMPLE_W(16), .GAIN_W(8), .OUT_W(OW)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
      .o_voice_index(o_voice_index), .o_slot(o_slot), .o_frame_start(o_frame_start),
      .i_sample_valid(i_sample_valid), .i_sample_voice(i_sample_voice), .i_sample(i_sample),
      .i_cfg_we(i_cfg_we), .i_cfg_voice(i_cfg_voice), .i_cfg_gain(i_cfg_gain), .i_cfg_pan(i_cfg_pan),
      .i_clip_clear(i_clip_clear), .o_left(o_left), .o_right(o_right), .o_valid(o_valid),
      .o_clip_left(o_clip_left), .o_clip_right(o_clip_right)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int     mg[NV], mp[NV];
   int     mn;
   longint macc_l, macc_r;
   bit     s1v;
   int     s1t, s1g, s1p;
   longint s1s;
   longint el, er;
   bit     ev, ecl, ecr;

   function automatic longint msat(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int mclamp(input int v);
      return (v > 256) ? 256 : v;
   endfunction

   always @(posedge i_clk) begin
      longint pp, l, r, tl, tr;
      if (i_reset) begin
         mn = 0; macc_l = 0; macc_r = 0; s1v = 0;
         el = 0; er = 0; ev = 0; ecl = 0; ecr = 0;
         for (int i = 0; i < NV; i++) begin mg[i] = 256; mp[i] = 128; end
      end else begin
         ev = 0;
         if (i_clip_clear) begin ecl = 0; ecr = 0; end
         if (s1v) begin
            pp = (s1s * s1g) >>> 8;
            l  = (pp * (256 - s1p)) >>> 8;
            r  = (pp * s1p) >>> 8;
            if (s1t == NV - 1) begin
               tl = macc_l + l; tr = macc_r + r;
               el = msat(tl); er = msat(tr); ev = 1;
               if (tl != el) ecl = 1;
               if (tr != er) ecr = 1;
               macc_l = 0; macc_r = 0;
            end else begin
               macc_l += l; macc_r += r;
            end
         end
         s1v = i_sample_valid && (int'(i_sample_voice) < NV);
         if (s1v) begin
            s1t = int'(i_sample_voice); s1s = i_sample; s1g = mg[s1t]; s1p = mp[s1t];
         end
         if (i_cfg_we && int'(i_cfg_voice) < NV) begin
            mg[i_cfg_voice] = mclamp(int'(i_cfg_gain));
            mp[i_cfg_voice] = mclamp(int'(i_cfg_pan));
         end
         if (i_enable) mn++;
      end
      #1;
      chk("m_voice", o_voice_index, (mn / 3) % NV);
      chk("m_slot", o_slot, mn % 3);
      chk("m_fstart", o_frame_start, (mn % (3 * NV)) == 0);
      chk("m_valid", o_valid, ev);
      chk("m_left", o_left, el);
      chk("m_right", o_right, er);
      chk("m_clipl", o_clip_left, ecl);
      chk("m_clipr", o_clip_right, ecr);
   end

   // ---------------- stimulus ----------------
   typedef struct packed {
      int             smp;
      logic [3:0]     m;
      logic [3:0][8:0] g;
      logic [3:0][8:0] p;
      int             el;
      int             er;
      logic           ecl;
      logic           ecr;
   } fvec_t;

   function automatic fvec_t mkv(input int smp, input logic [3:0] m, input logic [3:0][8:0] g,
                                 input logic [3:0][8:0] p, input int l, input int r,
                                 input logic cl, input logic cr);
      fvec_t v;
      v.smp = smp; v.m = m; v.g = g; v.p = p; v.el = l; v.er = r; v.ecl = cl; v.ecr = cr;
      return v;
   endfunction

   task automatic put(input bit sv, input int tag, input int s, input bit we,
                      input int cv, input int g, input int p);
      @(negedge i_clk);
      i_sample_valid = sv; i_sample_voice = 8'(tag); i_sample = 16'(s);
      i_cfg_we = we; i_cfg_voice = 8'(cv); i_cfg_gain = 9'(g); i_cfg_pan = 9'(p);
   endtask

   task automatic frame(input string nm, input logic [3:0] m, input int smp, input bit inj7,
                        input bit cfg0, input int cg, input longint xl, input longint xr);
      int lat;
      bit got;
      for (int t = 0; t < NV; t++) begin
         if (m[t]) begin
            put(1, t, smp, cfg0 && (t == 0), 0, cg, 128);
            if (inj7 && t == 1) put(1, 7, 30000, 0, 0, 0, 0);
         end
      end
      lat = 0; got = 0;
      while (!got && lat < 8) begin
         put(0, 0, 0, 0, 0, 0, 0);
         lat++;
         got = o_valid;
      end
      chk({nm, "_lat"}, lat, 2);
      chk({nm, "_left"}, o_left, xl);
      chk({nm, "_right"}, o_right, xr);
   endtask

   task automatic cfg_all(input logic [3:0][8:0] g, input logic [3:0][8:0] p);
      for (int v = 0; v < NV; v++) put(0, 0, 0, 1, v, int'(g[v]), int'(p[v]));
   endtask

   fvec_t vecs[8];
   int    sched_v[13];

   initial begin
      vecs[0] = mkv(1000, 4'hF, {4{9'd256}}, {4{9'd128}}, 2000, 2000, 0, 0);
      vecs[1] = mkv(-1000, 4'hF, {4{9'd256}}, {4{9'd128}}, -2000, -2000, 0, 0);
      vecs[2] = mkv(1000, 4'hF, {9'd256, 9'd256, 9'd128, 9'd256}, {9'd128, 9'd0, 9'd256, 9'd128}, 2000, 1500, 0, 0);
      vecs[3] = mkv(-3, 4'hF, {4{9'd256}}, {4{9'd128}}, -8, -8, 0, 0);
      vecs[4] = mkv(1000, 4'hF, {9'd256, 9'd256, 9'd256, 9'd511}, {9'd128, 9'd128, 9'd128, 9'd300}, 1500, 2500, 0, 0);
      vecs[5] = mkv(1000, 4'b1001, {4{9'd256}}, {4{9'd128}}, 1000, 1000, 0, 0);
      vecs[6] = mkv(32767, 4'hF, {4{9'd256}}, {4{9'd0}}, 32767, 0, 1, 0);
      vecs[7] = mkv(-32768, 4'hF, {4{9'd256}}, {4{9'd256}}, 0, -32768, 1, 1);
      sched_v = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

      repeat (3) @(negedge i_clk);
      i_reset = 1'b0;
      chk("rst_voice", o_voice_index, 0);
      chk("rst_slot", o_slot, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_left", o_left, 0);
      chk("rst_right", o_right, 0);
      chk("rst_clip", {o_clip_left, o_clip_right}, 0);

      i_enable = 1'b1;
      for (int i = 0; i < 13; i++) begin
         chk("sched_voice", o_voice_index, sched_v[i]);
         chk("sched_fstart", o_frame_start, (i == 0 || i == 12));
         if (i < 12) put(0, 0, 0, 0, 0, 0, 0);
      end
      i_enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         put(0, 0, 0, 0, 0, 0, 0);
         chk("freeze_voice", o_voice_index, 0);
         chk("freeze_slot", o_slot, 0);
      end
      i_enable = 1'b1;

      for (int k = 0; k < 8; k++) begin
         cfg_all(vecs[k].g, vecs[k].p);
         frame($sformatf("tbl%0d", k), vecs[k].m, vecs[k].smp, 0, 0, 0, vecs[k].el, vecs[k].er);
         chk($sformatf("tbl%0d_clipl", k), o_clip_left, vecs[k].ecl);
         chk($sformatf("tbl%0d_clipr", k), o_clip_right, vecs[k].ecr);
      end

      @(negedge i_clk) i_clip_clear = 1'b1;
      @(negedge i_clk) i_clip_clear = 1'b0;
      chk("clr_clipl", o_clip_left, 0);
      chk("clr_clipr", o_clip_right, 0);

      cfg_all({4{9'd256}}, {4{9'd128}});
      frame("tag7", 4'hF, 1000, 1, 0, 0, 2000, 2000);
      frame("cfg_old", 4'hF, 1000, 0, 1, 128, 2000, 2000);
      frame("cfg_new", 4'hF, 1000, 0, 0, 0, 1750, 1750);

      put(1, 0, 1000, 0, 0, 0, 0);
      put(1, 1, 1000, 0, 0, 0, 0);
      put(0, 0, 0, 0, 0, 0, 0);
      i_reset = 1'b1;
      put(0, 0, 0, 0, 0, 0, 0);
      i_reset = 1'b0;
      frame("post_rst", 4'hF, 1000, 0, 0, 0, 2000, 2000);

      for (int c = 0; c < 3000; c++) begin
         put($urandom_range(0, 1), $urandom_range(0, 7), int'($urandom_range(0, 65535)) - 32768,
             $urandom_range(0, 9) == 0, $urandom_range(0, 5), $urandom_range(0, 511), $urandom_range(0, 511));
         i_enable     = $urandom_range(0, 4) != 0;
         i_clip_clear = $urandom_range(0, 19) == 0;
         i_reset      = $urandom_range(0, 399) == 0;
      end
      i_reset = 1'b0; i_clip_clear = 1'b0;
      repeat (3) put(0, 0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
